sound_sequencer: RTL and testbench
==================================

# sound_sequencer

Shares the single speaker tone generator between up to NREQ sound requesters (background tune, game-event effects). Each requester names a start address in the shared note ROM. The sequencer grants one requester at a time by fixed priority, then walks the ROM from that address. It drives one note code per slot to the tone generator (note code 0 = rest) until it reads an end marker, then reports completion.

## Interface
- NREQ, 4: number of requesters; index 0 has the highest priority.
- ADDR_W, 8: note ROM address width.
- DUR_CYCLES, 4194304: clock cycles per note slot (about 168 ms at 25 MHz); must be at least GAP_CYCLES+1.
- GAP_CYCLES, 262144: trailing cycles of each slot forced to rest (articulation gap).
- clk  in  1  system clock, 25 MHz nominal.
- resetn  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester play request (level).
- req_addr  in  NREQ*ADDR_W  start addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- mute  in  1  forces note output to 0; sequencing continues.
- rom_addr  out  ADDR_W  note ROM read address.
- rom_data  in  8  note ROM data; registered, valid 1 cycle after rom_addr.
- note  out  8  note code to the tone generator; 0 = silence.
- note_valid  out  1  high while a sequence is playing (FETCH/LOAD/PLAY).
- grant  out  NREQ  one-hot owner of the tone generator.
- done  out  NREQ  one-cycle pulse on the owner when its sequence ends at the end marker.
- busy  out  1  state != IDLE.

## Operation
- States and transitions:
  - IDLE: wait for an eligible request.
  - FETCH: drive the ROM address.
  - LOAD: capture ROM data.
  - PLAY: hold the note for DUR_CYCLES.
  - DONE: pulse done, then return to IDLE.
- Eligibility: requester i is eligible when req[i]=1 and armed[i]=1.
  - armed[i] clears when done[i] pulses.
  - armed[i] sets on any cycle where req[i]=0.
  - This prevents an immediate replay from a held request.
- IDLE: choose the lowest-index eligible requester. Register owner, set grant, set ptr=req_addr[owner], go to FETCH.
- FETCH: rom_addr=ptr; go to LOAD.
- LOAD: rom_data==8'hFF is the end marker → DONE. Otherwise latch cur_note=rom_data, clear dur_cnt, go to PLAY.
- PLAY: dur_cnt increments each cycle.
  - note=cur_note while dur_cnt < DUR_CYCLES-GAP_CYCLES; otherwise note=0.
  - At dur_cnt==DUR_CYCLES-1: ptr=ptr+1 (wraps modulo 2^ADDR_W, no implicit end), go to FETCH.
- DONE: done[owner]=1 for one cycle, grant cleared, go to IDLE.
- Abort: if req[owner] drops in any non-IDLE state other than DONE:
  - next state is IDLE, grant cleared, note=0;
  - no done pulse;
  - armed is unaffected.
- note is forced to 0 whenever mute=1, when not in PLAY, or during the gap.
- A ROM value of 0 is a rest slot and still consumes a full slot.

## Timing
- Reset values: note=0, note_valid=0, grant=0, done=0, busy=0, rom_addr=0; state=IDLE, armed all 1.
- Start latency: eligible req seen in IDLE at cycle N gives:
  - N+1: grant and busy high, state FETCH;
  - N+2: state LOAD;
  - N+3: first note valid on the output.
- All outputs are registered.
- Slot period is DUR_CYCLES+2 cycles (FETCH and LOAD are silent).
- End: marker read in LOAD at cycle M → done pulse at M+1 → grant=0 and IDLE at M+2.
- Back-to-back: a new grant is possible at M+3.
- Simultaneous abort and end marker: abort wins, no done pulse.
- Reset mid-sequence takes effect immediately (asynchronous); all outputs return to reset values.

## Configuration
- SOUND_PREEMPT_EN defined: in FETCH/LOAD/PLAY, an eligible requester j < owner preempts.
  - The next cycle does the same as an IDLE grant to j (state FETCH, ptr=req_addr[j]).
  - No done pulse for the displaced owner; its armed bit is unchanged.
  - The displaced owner restarts from its start address when later re-granted.
- Undefined: no preemption; a higher-priority request waits until the current sequence ends or aborts.

## Test plan
Bench parameters: DUR_CYCLES=8, GAP_CYCLES=2.
- ROM {0x10:25, 0x11:27, 0x12:FF}; req[2]=1 with addr 0x10:
  - grant=0100 at N+1;
  - note=25 for 6 cycles, then 0 for 4 cycles, then 27 for 6 cycles;
  - done[2] pulse; grant=0 two cycles after the marker read.
- req[2] held high after done: no re-grant. Drop req[2] for 1 cycle, raise again → grant again.
- req[1] and req[3] both rise in the same IDLE cycle → grant=0010; req[3] is served after done[1].
- req[0] drops mid-PLAY → IDLE next cycle, note=0, no done.
- mute=1 during playback: note=0 throughout, slot timing unchanged, done pulses at the normal cycle.
- SOUND_PREEMPT_EN: req[0] rises during req[2] PLAY → next cycle grant=0001, rom_addr=req_addr[0], no done[2].
- Without SOUND_PREEMPT_EN: the same stimulus leaves grant=0100 until done[2].

Source files
------------

// File: rtl/sound_sequencer_if.sv
// Request/ROM/tone-generator bundle for sound_sequencer.
// The master side is the requesters plus the note ROM. The slave side is the sequencer.
interface sound_sequencer_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 8
);
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic                   mute;
  logic [ADDR_W-1:0]      rom_addr;
  logic [7:0]             rom_data;
  logic [7:0]             note;
  logic                   note_valid;
  logic [NREQ-1:0]        grant;
  logic [NREQ-1:0]        done;
  logic                   busy;

  modport master (
    output req, req_addr, mute, rom_data,
    input  rom_addr, note, note_valid, grant, done, busy
  );

  modport slave (
    input  req, req_addr, mute, rom_data,
    output rom_addr, note, note_valid, grant, done, busy
  );
endinterface

// File: rtl/sound_sequencer.sv
// sound_sequencer: shares one tone generator between NREQ requesters.
// Requesters are served by fixed priority, with index 0 highest. The sequencer walks the
// note ROM from the owner's start address until it reads the 8'hFF end marker.
// Optional feature: define SOUND_PREEMPT_EN to let a higher-priority eligible
// requester take over a sequence that is already playing.
module sound_sequencer #(
  parameter int NREQ       = 4,
  parameter int ADDR_W     = 8,
  parameter int DUR_CYCLES = 4194304,
  parameter int GAP_CYCLES = 262144
) (
  input logic              clk,
  input logic              resetn,
  sound_sequencer_if.slave bus
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(DUR_CYCLES + 1);
  localparam logic [CW-1:0] NOTE_END  = CW'(DUR_CYCLES - GAP_CYCLES);
  localparam logic [CW-1:0] SLOT_LAST = CW'(DUR_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        cur_note_q, cur_note_d;
  logic [CW-1:0]     dur_cnt_q, dur_cnt_d;
  logic [NREQ-1:0]   armed_q, armed_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]        note_q, note_d;
  logic              note_valid_q, note_valid_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;

  logic [NREQ-1:0]   eligible;
  logic              pick_vld;
  logic [OW-1:0]     pick;

  // Lowest-index requester that is requesting and re-armed since its last completion.
  always_comb begin
    eligible = bus.req & armed_q;
    pick_vld = 1'b0;
    pick     = '0;
    for (int unsigned i = unsigned'(NREQ); i > 0; i--) begin
      if (eligible[i-1]) begin
        pick_vld = 1'b1;
        pick     = OW'(i - 1);
      end
    end
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    cur_note_d = cur_note_q;
    dur_cnt_d  = dur_cnt_q;
    rom_addr_d = rom_addr_q;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_FETCH;
          owner_d = pick;
          ptr_d   = bus.req_addr[int'(pick)*ADDR_W +: ADDR_W];
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (bus.rom_data == 8'hFF) begin
          state_d = S_DONE;
        end else begin
          cur_note_d = bus.rom_data;
          dur_cnt_d  = '0;
          state_d    = S_PLAY;
        end
      end
      S_PLAY: begin
        dur_cnt_d = dur_cnt_q + 1'b1;
        if (dur_cnt_q == SLOT_LAST) begin
          ptr_d   = ptr_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything decided above, including an end marker read in the
    // same cycle. Preemption is only considered when the owner still holds its request.
    if (state_q == S_FETCH || state_q == S_LOAD || state_q == S_PLAY) begin
      if (!bus.req[owner_q]) begin
        state_d = S_IDLE;
      end
`ifdef SOUND_PREEMPT_EN
      else if (pick_vld && (pick < owner_q)) begin
        state_d = S_FETCH;
        owner_d = pick;
        ptr_d   = bus.req_addr[int'(pick)*ADDR_W +: ADDR_W];
      end
`else
      else begin
        state_d = state_d;
      end
`endif
    end

    // Outputs are derived from the next state so that they are registered with it.
    if (state_d == S_FETCH) begin
      rom_addr_d = ptr_d;
    end
    note_valid_d = (state_d == S_FETCH) || (state_d == S_LOAD) || (state_d == S_PLAY);
    busy_d       = (state_d != S_IDLE);
    grant_d      = '0;
    done_d       = '0;
    if (busy_d) begin
      grant_d[owner_d] = 1'b1;
    end
    if (state_d == S_DONE) begin
      done_d[owner_d] = 1'b1;
    end
    note_d = ((state_d == S_PLAY) && !bus.mute && (dur_cnt_d < NOTE_END)) ? cur_note_d : '0;

    // A completion disarms the owner. Any cycle with the request low re-arms it.
    armed_d = (armed_q & ~done_d) | ~bus.req;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      ptr_q        <= '0;
      cur_note_q   <= '0;
      dur_cnt_q    <= '0;
      armed_q      <= '1;
      rom_addr_q   <= '0;
      note_q       <= '0;
      note_valid_q <= 1'b0;
      grant_q      <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      cur_note_q   <= cur_note_d;
      dur_cnt_q    <= dur_cnt_d;
      armed_q      <= armed_d;
      rom_addr_q   <= rom_addr_d;
      note_q       <= note_d;
      note_valid_q <= note_valid_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.note       = note_q;
  assign bus.note_valid = note_valid_q;
  assign bus.grant      = grant_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_sound_sequencer.sv
// Testbench for sound_sequencer with DUR_CYCLES=8 and GAP_CYCLES=2.
// A sequence-level reference model locates the expected note by its offset from the
// grant cycle, using slot = offset / (DUR+2) and position = offset % (DUR+2).
// Directed literal expectations pin down that model.
module tb_sound_sequencer;
  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DUR  = 8;
  localparam int GAP  = 2;
  localparam int P    = DUR + 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sound_sequencer_if #(.NREQ(NREQ), .ADDR_W(AW)) bus ();

  sound_sequencer #(
    .NREQ(NREQ), .ADDR_W(AW), .DUR_CYCLES(DUR), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  logic [7:0] rom [256];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic       m_busy, m_done;
  int         m_owner, m_off, m_elig, m_pos, m_slot;
  logic [7:0] m_base, m_a;
  logic [3:0] m_armed;
  logic       m_new, m_enter_done;
  logic [7:0] e_note, e_addr;
  logic       e_nv, e_busy, e_chk_addr;
  logic [3:0] e_grant, e_done;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy = 0; m_done = 0; m_owner = 0; m_off = 0; m_base = 0; m_armed = '1;
      e_note = 0; e_nv = 0; e_busy = 0; e_grant = 0; e_done = 0; e_addr = 0; e_chk_addr = 1;
    end else begin
      m_elig = -1;
      for (int i = NREQ - 1; i >= 0; i--) if (bus.req[i] && m_armed[i]) m_elig = i;
      m_new = 0;
      m_enter_done = 0;
      if (m_done) begin
        m_done = 0; m_busy = 0;
      end else if (!m_busy) begin
        if (m_elig >= 0) m_new = 1;
      end else begin
        m_pos = m_off % P; m_slot = m_off / P; m_a = m_base + 8'(m_slot);
        if (!bus.req[m_owner]) m_busy = 0;
`ifdef SOUND_PREEMPT_EN
        else if (m_elig >= 0 && m_elig < m_owner) m_new = 1;
`endif
        else if (m_pos == 1 && rom[m_a] == 8'hFF) begin m_done = 1; m_enter_done = 1; end
        else m_off++;
      end
      if (m_new) begin
        m_busy = 1; m_done = 0; m_owner = m_elig; m_off = 0;
        m_base = bus.req_addr[m_elig*AW +: AW];
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req[i]) m_armed[i] = 1'b1;
        else if (m_enter_done && i == m_owner) m_armed[i] = 1'b0;
      end
      e_chk_addr = 0; e_note = 0; e_nv = 0; e_grant = 0; e_done = 0; e_busy = m_busy;
      if (m_busy) begin
        e_grant = 4'b0001 << m_owner;
        if (m_done) e_done = 4'b0001 << m_owner;
        else begin
          m_pos = m_off % P; m_slot = m_off / P; m_a = m_base + 8'(m_slot);
          e_nv = 1;
          if (m_pos == 0) begin e_chk_addr = 1; e_addr = m_a; end
          if (m_pos >= 2 && (m_pos - 2) < DUR - GAP && !bus.mute) e_note = rom[m_a];
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("model_note", bus.note, e_note);
    check("model_note_valid", bus.note_valid, e_nv);
    check("model_grant", bus.grant, e_grant);
    check("model_done", bus.done, e_done);
    check("model_busy", bus.busy, e_busy);
    if (e_chk_addr) check("model_rom_addr", bus.rom_addr, e_addr);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int limit, output logic seen);
    seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (bus.done != 0) seen = 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] starts [8];
  logic       seen;
  logic [7:0] en;
  int         b;

  initial begin : main
    for (int i = 0; i < 256; i++) rom[i] = 8'hFF;
    rom[8'h10] = 8'd25; rom[8'h11] = 8'd27; rom[8'h12] = 8'hFF;
    rom[8'h20] = 8'd3;  rom[8'h21] = 8'd0;  rom[8'h22] = 8'hFF;
    rom[8'h30] = 8'd7;  rom[8'h31] = 8'hFF;
    rom[8'h40] = 8'd9;  rom[8'h41] = 8'd10; rom[8'h42] = 8'd11; rom[8'h43] = 8'hFF;
    for (int i = 8'h80; i <= 8'hFD; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
    rom[8'hFE] = 8'd5; rom[8'hFF] = 8'd6; rom[8'h00] = 8'h33; rom[8'h01] = 8'hFF;
    starts = '{8'h10, 8'h20, 8'h30, 8'h40, 8'hFE, 8'h80, 8'hA0, 8'hC0};

    bus.req = '0; bus.mute = 1'b0;
    bus.req_addr = {8'h30, 8'h10, 8'h20, 8'h40};

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    check("reset_note", bus.note, 0);
    check("reset_note_valid", bus.note_valid, 0);
    check("reset_grant", bus.grant, 0);
    check("reset_done", bus.done, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_rom_addr", bus.rom_addr, 0);
    resetn = 1'b1;
    tick(); tick();

    // Basic playback of requester 2 from 0x10
    bus.req[2] = 1'b1;
    tick();
    check("t1_grant", bus.grant, 4'b0100);
    check("t1_busy", bus.busy, 1);
    check("t1_rom_addr", bus.rom_addr, 8'h10);
    tick();
    for (int k = 3; k <= 24; k++) begin
      tick();
      if (k <= 8) en = 8'd25;
      else if (k >= 13 && k <= 18) en = 8'd27;
      else en = 8'd0;
      check("t1_note", bus.note, en);
      check("t1_done", bus.done, (k == 23) ? 4'b0100 : 4'b0000);
    end
    check("t1_grant_end", bus.grant, 0);
    check("t1_busy_end", bus.busy, 0);

    // Held request is not replayed. A one-cycle drop re-arms it. Then abort it in FETCH.
    repeat (10) tick();
    check("t2_no_regrant", bus.grant, 0);
    bus.req[2] = 1'b0; tick();
    bus.req[2] = 1'b1; tick();
    check("t2_regrant", bus.grant, 4'b0100);
    bus.req[2] = 1'b0; tick();
    check("t2_abort_grant", bus.grant, 0);
    check("t2_abort_busy", bus.busy, 0);
    tick();

    // Simultaneous requesters 1 and 3
    bus.req[1] = 1'b1; bus.req[3] = 1'b1;
    tick();
    check("t3_grant1", bus.grant, 4'b0010);
    wait_done(200, seen);
    check("t3_done1_seen", seen, 1);
    check("t3_done1", bus.done, 4'b0010);
    tick();
    check("t3_idle_gap", bus.grant, 0);
    tick();
    check("t3_grant3", bus.grant, 4'b1000);
    wait_done(200, seen);
    check("t3_done3", bus.done, 4'b1000);
    bus.req[1] = 1'b0; bus.req[3] = 1'b0;
    tick(); tick();

    // Abort of requester 0 during PLAY
    bus.req[0] = 1'b1;
    tick();
    check("t4_grant", bus.grant, 4'b0001);
    tick(); tick(); tick();
    check("t4_note", bus.note, 8'd9);
    bus.req[0] = 1'b0;
    tick();
    check("t4_busy", bus.busy, 0);
    check("t4_grant_off", bus.grant, 0);
    check("t4_note_off", bus.note, 0);
    check("t4_no_done", bus.done, 0);
    repeat (3) tick();

    // Mute: silent output with unchanged timing
    bus.mute = 1'b1; bus.req[2] = 1'b1;
    tick();
    check("t5_grant", bus.grant, 4'b0100);
    for (int k = 2; k <= 24; k++) begin
      tick();
      check("t5_note", bus.note, 0);
      if (k == 23) check("t5_done", bus.done, 4'b0100);
    end
    check("t5_busy_end", bus.busy, 0);
    bus.req[2] = 1'b0; bus.mute = 1'b0;
    tick();

    // Higher-priority request while requester 2 is playing
    bus.req[2] = 1'b1;
    repeat (5) tick();
    bus.req[0] = 1'b1;
    tick();
`ifdef SOUND_PREEMPT_EN
    check("t6_preempt_grant", bus.grant, 4'b0001);
    check("t6_preempt_addr", bus.rom_addr, 8'h40);
    check("t6_no_done2", bus.done, 0);
    wait_done(200, seen);
    check("t6_done0", bus.done, 4'b0001);
`else
    check("t6_keep_grant", bus.grant, 4'b0100);
    wait_done(200, seen);
    check("t6_done2", bus.done, 4'b0100);
    tick(); tick();
    check("t6_grant0_after", bus.grant, 4'b0001);
`endif
    bus.req = '0;
    repeat (3) tick();

    // Asynchronous reset in the middle of a sequence
    bus.req[3] = 1'b1;
    repeat (5) tick();
    resetn = 1'b0;
    #1;
    check("t7_rst_grant", bus.grant, 0);
    check("t7_rst_busy", bus.busy, 0);
    check("t7_rst_nv", bus.note_valid, 0);
    check("t7_rst_addr", bus.rom_addr, 0);
    tick();
    resetn = 1'b1;
    repeat (4) tick();
    bus.req = '0;
    tick();

    // Randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        b = $urandom_range(0, 3);
        bus.req[b] = ~bus.req[b];
      end
      if ($urandom_range(0, 79) == 0) bus.mute = ~bus.mute;
      if ($urandom_range(0, 99) == 0) begin
        b = $urandom_range(0, 3);
        bus.req_addr[b*AW +: AW] = starts[$urandom_range(0, 7)];
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
